rca_accumulator: RTL and testbench

//  Streaming accumulator that sits directly downstream of the 4-bit ripple-carry adder datapath.
//  It accepts WIDTH-bit operands plus a carry-in over a valid/ready handshake.
//  It sums COUNT operands into an ACC_W-bit register using a ripple-carry adder chain.
//  It then presents the block total, with an overflow flag, on a valid/ready output.

---
 rtl/rca_acc_pkg.sv | 15 +
 rtl/adder_rca_n.sv | 25 ++
 rtl/rca_accumulator.sv | 120 ++++++++++++
 tb/tb_rca_accumulator.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_acc_pkg.sv
// Shared types and default parameters for the ripple-carry streaming accumulator.
// Latency: n/a (types only). Backpressure: n/a.
// Build option ACC_SATURATE_EN is consumed by rca_accumulator, not here.
package rca_acc_pkg;

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    localparam int WIDTH_D = 4;
    localparam int ACC_W_D = 8;
    localparam int COUNT_D = 4;

endpackage

// File: rtl/adder_rca_n.sv
// Combinational N-bit ripple-carry adder built from a chain of full-adder cells.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Carry ripples LSB to MSB; cout is the carry out of bit N-1.
module adder_rca_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[N];

endmodule

// File: rtl/rca_accumulator.sv
// Sums COUNT operands (+carry-in) per block and presents the total with an overflow flag.
// Latency: result valid 1 cycle after the last accept. Backpressure: in_ready=0 while a result waits on out_ready.
// Build option ACC_SATURATE_EN: saturate the accumulator on carry-out instead of wrapping.
module rca_accumulator
    import rca_acc_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int ACC_W = ACC_W_D,
    parameter int COUNT = COUNT_D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int CNT_W = $clog2(COUNT + 1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0]   add_b;
    logic [ACC_W-1:0]   add_sum;
    logic               add_cout;
    logic [ACC_W-1:0]   acc_next;
    logic               last_beat;

    assign add_b = ACC_W'(in_data);

    adder_rca_n #(.N(ACC_W)) u_add (
        .a    (acc_q),
        .b    (add_b),
        .cin  (in_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Once saturated, every later non-zero add carries out again, so the block stays pinned.
`ifdef ACC_SATURATE_EN
    assign acc_next = add_cout ? {ACC_W{1'b1}} : add_sum;
`else
    assign acc_next = add_sum;
`endif

    assign last_beat = (cnt_q == CNT_W'(COUNT - 1));

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_sum_d = out_sum_q;
        out_ovf_d = out_ovf_q;
        if (clear) begin
            state_d = S_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                S_ACC: begin
                    if (in_valid) begin
                        acc_d = acc_next;
                        ovf_d = ovf_q | add_cout;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (last_beat) begin
                            state_d   = S_OUT;
                            out_sum_d = acc_next;
                            out_ovf_d = ovf_q | add_cout;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state_d = S_ACC;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = S_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_sum_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            out_sum_q <= out_sum_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = (state_q == S_OUT);
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_rca_accumulator.sv
// Drives an 8-bit and a 5-bit accumulator with identical stimulus and checks both
// against a block-level sum model plus hand-computed literal expectations.
module tb_rca_accumulator;

    localparam int COUNT = 4;

`ifdef ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_cin;
    logic       out_ready;

    logic       in_ready8, out_valid8, out_ovf8;
    logic [7:0] out_sum8;
    logic       in_ready5, out_valid5, out_ovf5;
    logic [4:0] out_sum5;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rca_accumulator #(.WIDTH(4), .ACC_W(8), .COUNT(COUNT)) dut8 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data), .in_cin(in_cin),
        .out_valid(out_valid8), .out_ready(out_ready), .out_sum(out_sum8), .out_ovf(out_ovf8)
    );

    rca_accumulator #(.WIDTH(4), .ACC_W(5), .COUNT(COUNT)) dut5 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready5), .in_data(in_data), .in_cin(in_cin),
        .out_valid(out_valid5), .out_ready(out_ready), .out_sum(out_sum5), .out_ovf(out_ovf5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Block-level model: the true (unbounded) total of each block decides both outputs.
    function automatic int exp_sum(input int total, input int w);
        int lim = 1 << w;
        if (total >= lim) return SAT ? lim - 1 : total % lim;
        return total;
    endfunction

    function automatic bit exp_ovf(input int total, input int w);
        return total >= (1 << w);
    endfunction

    bit m_pres;
    int m_cnt;
    int m_run;
    int m_blk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pres <= 1'b0;
            m_cnt  <= 0;
            m_run  <= 0;
            m_blk  <= 0;
        end else if (clear) begin
            m_pres <= 1'b0;
            m_cnt  <= 0;
            m_run  <= 0;
        end else if (!m_pres) begin
            if (in_valid) begin
                if (m_cnt == COUNT - 1) begin
                    m_pres <= 1'b1;
                    m_blk  <= m_run + int'(in_data) + int'(in_cin);
                    m_cnt  <= 0;
                    m_run  <= 0;
                end else begin
                    m_cnt <= m_cnt + 1;
                    m_run <= m_run + int'(in_data) + int'(in_cin);
                end
            end
        end else if (out_ready) begin
            m_pres <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("m_in_ready8",  32'(in_ready8),  32'(!m_pres));
        chk("m_out_valid8", 32'(out_valid8), 32'(m_pres));
        chk("m_in_ready5",  32'(in_ready5),  32'(!m_pres));
        chk("m_out_valid5", 32'(out_valid5), 32'(m_pres));
        if (m_pres) begin
            chk("m_out_sum8", 32'(out_sum8), 32'(exp_sum(m_blk, 8)));
            chk("m_out_ovf8", 32'(out_ovf8), 32'(exp_ovf(m_blk, 8)));
            chk("m_out_sum5", 32'(out_sum5), 32'(exp_sum(m_blk, 5)));
            chk("m_out_ovf5", 32'(out_ovf5), 32'(exp_ovf(m_blk, 5)));
        end
    end

    task automatic send(input logic [3:0] d, input logic c);
        logic r;
        bit   ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_cin   = c;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            r = in_ready8;
            @(posedge clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: operand 0x%0h never accepted", d);
        end
    endtask

    task automatic wait_out(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid8) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: out_valid never rose", name);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("consume_out_valid", 32'(out_valid8), 32'd0);
        chk("consume_in_ready",  32'(in_ready8),  32'd1);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_cin = 1'b0; out_ready = 1'b0;
        #23;
        chk("rst_in_ready",  32'(in_ready8),  32'd1);
        chk("rst_out_valid", 32'(out_valid8), 32'd0);
        chk("rst_out_sum",   32'(out_sum8),   32'd0);
        chk("rst_out_ovf",   32'(out_ovf8),   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Four 0xF, cin=0: 60 -> 0x3C on 8 bits; 0x1C with overflow on 5 bits.
        for (int i = 0; i < 4; i++) send(4'hF, 1'b0);
        chk("t1_latency_valid", 32'(out_valid8), 32'd1);
        chk("t1_sum8", 32'(out_sum8), 32'h3C);
        chk("t1_ovf8", 32'(out_ovf8), 32'd0);
        chk("t3_sum5", 32'(out_sum5), SAT ? 32'h1F : 32'h1C);
        chk("t3_ovf5", 32'(out_ovf5), 32'd1);
        consume();

        // Four 0xF, cin=1: 64 -> 0x40; on 5 bits wraps to 0 (or saturates).
        for (int i = 0; i < 4; i++) send(4'hF, 1'b1);
        wait_out("t2");
        chk("t2_sum8", 32'(out_sum8), 32'h40);
        chk("t2_ovf8", 32'(out_ovf8), 32'd0);
        chk("t2_sum5", 32'(out_sum5), SAT ? 32'h1F : 32'h00);
        chk("t2_ovf5", 32'(out_ovf5), 32'd1);

        // Hold the result with an operand pushing against it.
        in_valid = 1'b1; in_data = 4'h9; in_cin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_in_ready", 32'(in_ready8), 32'd0);
            chk("t4_hold_sum",      32'(out_sum8),  32'h40);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        consume();
        send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
        wait_out("t4");
        chk("t4_next_sum8", 32'(out_sum8), 32'h0A);
        chk("t4_next_ovf5", 32'(out_ovf5), 32'd0);
        consume();

        // Abort a partial block; the operand offered with clear must vanish.
        send(4'h3, 1'b0); send(4'h5, 1'b0);
        clear = 1'b1; in_valid = 1'b1; in_data = 4'h7; in_cin = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) send(4'h1, 1'b0);
        wait_out("t5");
        chk("t5_sum8", 32'(out_sum8), 32'h04);
        chk("t5_ovf8", 32'(out_ovf8), 32'd0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("t5_clear_out_valid", 32'(out_valid8), 32'd0);
        chk("t5_clear_in_ready",  32'(in_ready8),  32'd1);

        // Asynchronous reset in the middle of a block.
        for (int i = 0; i < 3; i++) send(4'h2, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_in_ready",  32'(in_ready8),  32'd1);
        chk("t6_rst_out_valid", 32'(out_valid8), 32'd0);
        chk("t6_rst_out_sum",   32'(out_sum8),   32'd0);
        chk("t6_rst_out_ovf",   32'(out_ovf8),   32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_stale_valid", 32'(out_valid8), 32'd0);
        for (int i = 0; i < 4; i++) send(4'h2, 1'b0);
        wait_out("t6");
        chk("t6_sum8", 32'(out_sum8), 32'h08);
        consume();

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
